// File: rtl/i2c_pkg.sv
// Shared I2C command encoding and address width for the transaction sequencer
// and the byte engine it drives.
package i2c_pkg;

    localparam int ADDR_W = 7;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } cmd_code_e;

endpackage

// File: rtl/i2c_txn_sequencer.sv
// Turns one {addr, rw, len} descriptor into START / address / data / STOP
// commands for an I2C byte engine, one command outstanding at a time.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; a valid source holds its payload until that edge.
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_rw_i,
    input  logic [LEN_W-1:0]  req_len_i,
    input  logic [7:0]        wr_data_i,
    input  logic              wr_data_valid_i,
    output logic              wr_data_ready_o,
    output logic [7:0]        rd_data_o,
    output logic              rd_data_valid_o,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [1:0]        cmd_code_o,
    output logic [7:0]        cmd_data_o,
    output logic              cmd_nack_o,
    input  logic              rsp_valid_i,
    input  logic              rsp_ack_i,
    input  logic [7:0]        rsp_data_i,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_ADDR      = 3'd2,
        S_ADDR_WAIT = 3'd3,
        S_DATA      = 3'd4,
        S_DATA_WAIT = 3'd5,
        S_STOP      = 3'd6,
        S_DONE      = 3'd7
    } state_e;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic              nack_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              accept;
    logic              last_byte;
    cmd_code_e         cmd_code;

    assign accept      = (state_q == S_IDLE) && req_valid_i;
    // A zero count never reaches DATA; treat it as final so the counter cannot wrap.
    assign last_byte   = (cnt_q <= CNT_ONE);
    assign cmd_code_o  = cmd_code;
    assign state_dbg_o = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            rw_q   <= 1'b0;
            cnt_q  <= '0;
            nack_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr_i;
                rw_q   <= req_rw_i;
                cnt_q  <= req_len_i;
                nack_q <= 1'b0;
            end
            if (state_q == S_ADDR_WAIT && rsp_valid_i && !rsp_ack_i) begin
                nack_q <= 1'b1;
            end
            if (state_q == S_DATA_WAIT && rsp_valid_i) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_ONE;
                end
                if (!rw_q && !rsp_ack_i) begin
                    nack_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        req_ready_o     = 1'b0;
        cmd_valid_o     = 1'b0;
        cmd_code        = CMD_START;
        cmd_data_o      = '0;
        cmd_nack_o      = 1'b0;
        wr_data_ready_o = 1'b0;
        rd_data_valid_o = 1'b0;
        rd_data_o       = '0;
        done_o          = 1'b0;
        err_o           = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = S_START;
            end
            S_START: begin
                cmd_valid_o = 1'b1;
                if (cmd_ready_i) state_d = S_ADDR;
            end
            S_ADDR: begin
                cmd_valid_o = 1'b1;
                cmd_code    = CMD_WRITE;
                cmd_data_o  = {addr_q, rw_q};
                if (cmd_ready_i) state_d = S_ADDR_WAIT;
            end
            S_ADDR_WAIT: begin
                if (rsp_valid_i) begin
                    state_d = (!rsp_ack_i || cnt_q == '0) ? S_STOP : S_DATA;
                end
            end
            S_DATA: begin
                if (!rw_q) begin
                    // Write bytes pass straight through from the stream to the engine.
                    wr_data_ready_o = cmd_ready_i;
                    cmd_valid_o     = wr_data_valid_i;
                    cmd_code        = CMD_WRITE;
                    cmd_data_o      = wr_data_i;
                    if (wr_data_valid_i && cmd_ready_i) state_d = S_DATA_WAIT;
                end else begin
                    cmd_valid_o = 1'b1;
                    cmd_code    = CMD_READ;
                    cmd_nack_o  = last_byte;
                    if (cmd_ready_i) state_d = S_DATA_WAIT;
                end
            end
            S_DATA_WAIT: begin
                if (rsp_valid_i) begin
                    if (rw_q) begin
                        rd_data_valid_o = 1'b1;
                        rd_data_o       = rsp_data_i;
                    end
                    if ((!rw_q && !rsp_ack_i) || last_byte) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_STOP: begin
                cmd_valid_o = 1'b1;
                cmd_code    = CMD_STOP;
                if (cmd_ready_i) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                err_o   = nack_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: a scripted byte-engine model answers
// commands, and every command, read byte, done/err and latency is checked.
module tb_i2c_txn_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd4,
                           ST_DATA_WAIT = 3'd5, ST_STOP = 3'd6;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req_valid_i, req_ready_o, req_rw_i;
    logic [6:0] req_addr_i;
    logic [3:0] req_len_i;
    logic [7:0] wr_data_i;
    logic       wr_data_valid_i, wr_data_ready_o;
    logic [7:0] rd_data_o;
    logic       rd_data_valid_o;
    logic       cmd_valid_o, cmd_ready_i, cmd_nack_o;
    logic [1:0] cmd_code_o;
    logic [7:0] cmd_data_o;
    logic       rsp_valid_i, rsp_ack_i;
    logic [7:0] rsp_data_i;
    logic       done_o, err_o;
    logic [2:0] state_dbg_o;

    i2c_txn_sequencer #(.LEN_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_rw_i(req_rw_i), .req_len_i(req_len_i),
        .wr_data_i(wr_data_i), .wr_data_valid_i(wr_data_valid_i),
        .wr_data_ready_o(wr_data_ready_o),
        .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_code_o(cmd_code_o), .cmd_data_o(cmd_data_o), .cmd_nack_o(cmd_nack_o),
        .rsp_valid_i(rsp_valid_i), .rsp_ack_i(rsp_ack_i), .rsp_data_i(rsp_data_i),
        .done_o(done_o), .err_o(err_o), .state_dbg_o(state_dbg_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_bad   = 0;

    logic [10:0] exp_q[$];     // {code, data, nack}
    logic [7:0]  exp_rd_q[$];
    logic [8:0]  rsp_q[$];     // {ack, data}
    logic [7:0]  wr_bytes[0:7];
    int          wr_n, wr_idx;
    int          stall_start, stall_stop;
    int          cyc, acc_cyc, done_cyc, done_cnt, wr_ready_seen;
    logic        last_err;
    bit          pend_rsp, adv_wr, was_stalled;
    logic [10:0] stall_cmd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] cmd(input logic [1:0] code, input logic [7:0] data,
                                        input logic nack);
        return {code, data, nack};
    endfunction

    // ---------------- byte-engine model and monitor ----------------
    always @(negedge clk_i) begin
        logic [8:0]  r;
        logic [10:0] c;
        if (adv_wr) begin
            wr_idx++;
            wr_data_i       = (wr_idx < wr_n) ? wr_bytes[wr_idx] : 8'h00;
            wr_data_valid_i = (wr_idx < wr_n);
            adv_wr          = 1'b0;
        end
        rsp_valid_i = 1'b0;
        rsp_ack_i   = 1'b0;
        rsp_data_i  = 8'h00;
        if (pend_rsp) begin
            r           = (rsp_q.size() > 0) ? rsp_q.pop_front() : 9'h100;
            rsp_valid_i = 1'b1;
            rsp_ack_i   = r[8];
            rsp_data_i  = r[7:0];
            pend_rsp    = 1'b0;
        end
        cmd_ready_i = 1'b1;
        if (state_dbg_o == ST_START && stall_start > 0) begin
            cmd_ready_i = 1'b0;
            stall_start--;
        end else if (state_dbg_o == ST_STOP && stall_stop > 0) begin
            cmd_ready_i = 1'b0;
            stall_stop--;
        end

        #1;
        c = {cmd_code_o, cmd_data_o, cmd_nack_o};
        if (req_valid_i && req_ready_o) acc_cyc = cyc;
        if (wr_data_ready_o) wr_ready_seen++;
        if (cmd_valid_o && !cmd_ready_i) begin
            if (was_stalled) check("stall_stable", c, stall_cmd);
            stall_cmd   = c;
            was_stalled = 1'b1;
        end else begin
            was_stalled = 1'b0;
        end
        if (cmd_valid_o && cmd_ready_i) begin
            if (exp_q.size() > 0) check("cmd", c, exp_q.pop_front());
            else check("cmd_extra", c, 11'h7ff);
            pend_rsp = (cmd_code_o == 2'd1 || cmd_code_o == 2'd2);
            if (state_dbg_o == ST_DATA && cmd_code_o == 2'd1) adv_wr = 1'b1;
        end
        if (rd_data_valid_o) begin
            if (exp_rd_q.size() > 0) check("rd_data", rd_data_o, exp_rd_q.pop_front());
            else check("rd_extra", 1, 0);
        end
        if (done_o) begin
            done_cyc = cyc;
            last_err = err_o;
            done_cnt++;
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic load_wr(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
        wr_bytes[0]     = b0;
        wr_bytes[1]     = b1;
        wr_bytes[2]     = b2;
        wr_n            = n;
        wr_idx          = 0;
        wr_data_i       = (n > 0) ? b0 : 8'h00;
        wr_data_valid_i = (n > 0);
    endtask

    task automatic run_txn(input string tag, input logic [6:0] addr, input logic rw,
                           input logic [3:0] len, input logic exp_err, input int exp_lat);
        int d0;
        bit got;
        @(negedge clk_i);
        d0          = done_cnt;
        req_addr_i  = addr;
        req_rw_i    = rw;
        req_len_i   = len;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_addr_i  = 7'h00;
        req_rw_i    = 1'b0;
        req_len_i   = 4'h0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #2;
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        check({tag, "_done_seen"}, got, 1);
        if (got) begin
            check({tag, "_err"}, last_err, exp_err);
            check({tag, "_latency"}, done_cyc - acc_cyc, exp_lat);
        end
        check({tag, "_cmd_left"}, exp_q.size(), 0);
        check({tag, "_rd_left"}, exp_rd_q.size(), 0);
        wr_data_valid_i = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        bit hit;
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_addr_i = 7'h00; req_rw_i = 1'b0; req_len_i = 4'h0;
        wr_data_i = 8'h00; wr_data_valid_i = 1'b0;
        cmd_ready_i = 1'b1; rsp_valid_i = 1'b0; rsp_ack_i = 1'b0; rsp_data_i = 8'h00;
        wr_n = 0; wr_idx = 0; stall_start = 0; stall_stop = 0;
        cyc = 0; acc_cyc = 0; done_cyc = 0; done_cnt = 0; wr_ready_seen = 0;
        last_err = 1'b0; pend_rsp = 1'b0; adv_wr = 1'b0; was_stalled = 1'b0;
        stall_cmd = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        check("rst_state", state_dbg_o, ST_IDLE);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_cmd_valid", cmd_valid_o, 0);
        check("rst_wr_ready", wr_data_ready_o, 0);
        check("rst_rd_valid", rd_data_valid_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_cmd", {cmd_code_o, cmd_data_o, cmd_nack_o}, cmd(2'd0, 8'h00, 1'b0));

        // write 0x50, two bytes, all ACK
        exp_q = '{cmd(0, 8'h00, 0), cmd(1, 8'hA0, 0), cmd(1, 8'hA5, 0), cmd(1, 8'h3C, 0),
                  cmd(3, 8'h00, 0)};
        rsp_q = '{9'h100, 9'h100, 9'h100};
        load_wr(2, 8'hA5, 8'h3C, 8'h00);
        run_txn("wr2", 7'h50, 1'b0, 4'd2, 1'b0, 9);

        // read 0x50, three bytes, NACK flag only on the last READ
        exp_q = '{cmd(0, 8'h00, 0), cmd(1, 8'hA1, 0), cmd(2, 8'h00, 0), cmd(2, 8'h00, 0),
                  cmd(2, 8'h00, 1), cmd(3, 8'h00, 0)};
        rsp_q = '{9'h100, 9'h111, 9'h122, 9'h133};
        exp_rd_q = '{8'h11, 8'h22, 8'h33};
        load_wr(0, 8'h00, 8'h00, 8'h00);
        run_txn("rd3", 7'h50, 1'b1, 4'd3, 1'b0, 11);

        // address NACK on a four-byte write: no data phase at all
        exp_q = '{cmd(0, 8'h00, 0), cmd(1, 8'h54, 0), cmd(3, 8'h00, 0)};
        rsp_q = '{9'h000};
        load_wr(3, 8'hDE, 8'hAD, 8'hBE);
        wr_ready_seen = 0;
        run_txn("addr_nack", 7'h2A, 1'b0, 4'd4, 1'b1, 5);
        check("addr_nack_wr_ready", wr_ready_seen, 0);

        // data NACK on the second of three write bytes ends the transfer early
        exp_q = '{cmd(0, 8'h00, 0), cmd(1, 8'h20, 0), cmd(1, 8'h01, 0), cmd(1, 8'h02, 0),
                  cmd(3, 8'h00, 0)};
        rsp_q = '{9'h100, 9'h100, 9'h000};
        load_wr(3, 8'h01, 8'h02, 8'h03);
        run_txn("data_nack", 7'h10, 1'b0, 4'd3, 1'b1, 9);

        // len 0 read probe with engine stalls: 3 cycles on START, 1 on STOP
        exp_q = '{cmd(0, 8'h00, 0), cmd(1, 8'h77, 0), cmd(3, 8'h00, 0)};
        rsp_q = '{9'h100};
        load_wr(0, 8'h00, 8'h00, 8'h00);
        stall_start = 3;
        stall_stop  = 1;
        run_txn("probe", 7'h3B, 1'b1, 4'd0, 1'b0, 9);

        // reset during DATA_WAIT abandons the read: no STOP, no done
        exp_q = '{cmd(0, 8'h00, 0), cmd(1, 8'hA1, 0), cmd(2, 8'h00, 0)};
        rsp_q = '{9'h100, 9'h111, 9'h122, 9'h133};
        exp_rd_q = '{8'h11};
        @(negedge clk_i);
        d0 = done_cnt;
        req_addr_i = 7'h50; req_rw_i = 1'b1; req_len_i = 4'd3; req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #2;
            if (state_dbg_o == ST_DATA_WAIT) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        check("rstmid_reached_wait", hit, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        #2;
        check("rstmid_state", state_dbg_o, ST_IDLE);
        check("rstmid_req_ready", req_ready_o, 1);
        rst_i = 1'b0;
        rsp_q.delete();
        exp_q.delete();
        exp_rd_q.delete();
        repeat (10) @(negedge clk_i);
        #2;
        check("rstmid_no_done", done_cnt - d0, 0);
        check("rstmid_idle_after", state_dbg_o, ST_IDLE);
        check("rstmid_cmd_valid", cmd_valid_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
